// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Bus widths, default NOP encoding, FSM encoding, counter width helper.
package inst_fetch_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;

  localparam logic [INST_DATA_W-1:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_timeout_cnt.sv
// Per-fetch bus timeout counter: clear, enable, terminal-count output.
// Ports: clk, rst, i_clr, i_en in; o_tc out (count == TIMEOUT_CYC-1).
module inst_fetch_ctrl_timeout_cnt
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == TC_VAL);

  // Saturates at terminal count; the FSM leaves the wait state there.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one-entry holding register, bus FSM.
// Ports: core side (ce/addr/data/stall/flush), bus side (req/addr/ack/rdata), err.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [INST_DATA_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_ce_i,
  input  logic [INST_ADDR_W-1:0] core_addr_i,
  output logic [INST_DATA_W-1:0] core_data_o,
  output logic                   stallreq_o,
  input  logic                   flush_i,
  output logic                   bus_req_o,
  output logic [INST_ADDR_W-1:0] bus_addr_o,
  input  logic                   bus_ack_i,
  input  logic [INST_DATA_W-1:0] bus_rdata_i,
  output logic                   err_o
);

  fetch_state_t r_state;
  fetch_state_t w_state_n;

  logic [INST_DATA_W-1:0] r_data;
  logic [INST_DATA_W-1:0] w_data_n;
  logic [INST_ADDR_W-1:0] r_tag;
  logic [INST_ADDR_W-1:0] w_tag_n;
  logic                   r_valid;
  logic                   w_valid_n;
  logic                   r_req;
  logic                   w_req_n;
  logic [INST_ADDR_W-1:0] r_addr;
  logic [INST_ADDR_W-1:0] w_addr_n;
  logic                   r_err;
  logic                   w_err_n;

  logic w_hit;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_tc;

  // Gating with rst keeps the core stalled on NOP while in reset.
  assign w_hit = !rst && (r_state == ST_IDLE) && r_valid
               && (r_tag == core_addr_i);

  assign core_data_o = w_hit ? r_data : NOP_INST;
  assign stallreq_o  = core_ce_i && !w_hit;
  assign bus_req_o   = r_req;
  assign bus_addr_o  = r_addr;
  assign err_o       = r_err;

  assign w_cnt_en = (r_state != ST_IDLE);

  inst_fetch_ctrl_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tocnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_state_n = r_state;
    w_data_n  = r_data;
    w_tag_n   = r_tag;
    w_valid_n = r_valid && !flush_i;
    w_req_n   = r_req;
    w_addr_n  = r_addr;
    w_err_n   = 1'b0;
    w_cnt_clr = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (core_ce_i && !w_hit && !flush_i) begin
          w_state_n = ST_BUSY;
          w_req_n   = 1'b1;
          w_addr_n  = core_addr_i;
          w_cnt_clr = 1'b1;
        end
      end
      ST_BUSY: begin
        // Timeout wins over a same-cycle ack.
        if (w_tc) begin
          w_state_n = ST_IDLE;
          w_req_n   = 1'b0;
          w_data_n  = NOP_INST;
          w_tag_n   = r_addr;
          w_valid_n = !flush_i;
          w_err_n   = 1'b1;
        end else if (bus_ack_i) begin
          w_state_n = ST_IDLE;
          w_req_n   = 1'b0;
          if (!flush_i) begin
            w_data_n  = bus_rdata_i;
            w_tag_n   = r_addr;
            w_valid_n = 1'b1;
          end
        end else if (flush_i) begin
          w_state_n = ST_DRAIN;
          w_cnt_clr = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_tc || bus_ack_i) begin
          w_state_n = ST_IDLE;
          w_req_n   = 1'b0;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_data  <= w_data_n;
      r_tag   <= w_tag_n;
      r_valid <= w_valid_n;
      r_req   <= w_req_n;
      r_addr  <= w_addr_n;
      r_err   <= w_err_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a bus responder model,
// a request monitor and a scoreboard of expected fetched instructions.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam int unsigned TO = 8;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        core_ce_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_data_o;
  logic        stallreq_o;
  logic        flush_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];

  int req_cnt = 0;
  int err_cnt = 0;
  int cur_len = 0;
  int last_len = 0;
  logic prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  bit resp_en = 0;
  int lat = 1;
  int age = 0;
  int inj_req = 0;
  int inj_seen = 0;
  logic [31:0] inj_data = '0;

  inst_fetch_ctrl #(
    .TIMEOUT_CYC (TO),
    .NOP_INST    (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_ce_i   (core_ce_i),
    .core_addr_i (core_addr_i),
    .core_data_o (core_data_o),
    .stallreq_o  (stallreq_o),
    .flush_i     (flush_i),
    .bus_req_o   (bus_req_o),
    .bus_addr_o  (bus_addr_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .err_o       (err_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h4) return 32'h3401_0100;
    return (a * 32'h0001_0001) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Bus memory: acks after 'lat' request cycles, or once on injection.
  initial begin
    bus_ack_i = 0;
    bus_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_ack_i = 0;
      if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        bus_ack_i = 1;
        bus_rdata_i = inj_data;
        age = 0;
      end else if (resp_en && bus_req_o) begin
        age++;
        if (age >= lat) begin
          bus_ack_i = 1;
          bus_rdata_i = mem(bus_addr_o);
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Request monitor: counts requests, checks address stability.
  always @(negedge clk) begin
    if (bus_req_o && prev_req)
      chk("addr_stable", bus_addr_o, prev_addr);
    if (bus_req_o && !prev_req) begin
      req_cnt++;
      req_log.push_back(bus_addr_o);
    end
    if (bus_req_o) cur_len++;
    else if (prev_req) begin
      last_len = cur_len;
      cur_len = 0;
    end
    if (err_o) err_cnt++;
    prev_req = bus_req_o;
    prev_addr = bus_addr_o;
  end

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] d,
                       input int exp_stall);
    int n;
    n = 0;
    core_ce_i = 1;
    core_addr_i = a;
    exp_q.push_back(d);
    #1;
    while (stallreq_o && n < 40) begin
      cyc();
      #1;
      n++;
    end
    chk("stall_cycles", n, exp_stall);
    chk("core_data", core_data_o, exp_q.pop_front());
  endtask

  initial begin
    rst = 1;
    core_ce_i = 1;
    core_addr_i = '0;
    flush_i = 0;
    cyc();
    cyc();
    #1;
    chk("rst_req", bus_req_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", core_data_o, NOP);
    chk("rst_stall", stallreq_o, 1);

    // Fetch port disabled.
    rst = 0;
    core_ce_i = 0;
    core_addr_i = 32'h300;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("ceoff_req", bus_req_o, 0);
      chk("ceoff_stall", stallreq_o, 0);
      chk("ceoff_data", core_data_o, NOP);
    end

    // Single miss, minimum latency.
    resp_en = 1;
    lat = 1;
    fetch(32'h4, 32'h3401_0100, 2);

    // Back-to-back misses, 3-cycle ack latency.
    lat = 3;
    req_log.delete();
    fetch(32'h0, mem(32'h0), 4);
    fetch(32'h4, mem(32'h4), 4);
    fetch(32'h8, mem(32'h8), 4);
    chk("b2b_nreq", req_log.size(), 3);
    chk("b2b_a0", req_log[0], 32'h0);
    chk("b2b_a1", req_log[1], 32'h4);
    chk("b2b_a2", req_log[2], 32'h8);

    // Flush in IDLE on a miss: no request, holding reg invalidated.
    resp_en = 0;
    core_addr_i = 32'h20;
    flush_i = 1;
    cyc();
    flush_i = 0;
    core_ce_i = 0;
    #1;
    chk("idleflush_req", bus_req_o, 0);
    core_ce_i = 1;
    core_addr_i = 32'h8;
    #1;
    chk("idleflush_inval", stallreq_o, 1);
    resp_en = 1;
    lat = 1;
    fetch(32'h8, mem(32'h8), 2);

    // Flush mid-fetch: drain the stale ack.
    resp_en = 0;
    req_log.delete();
    core_addr_i = 32'h10;
    cyc();
    flush_i = 1;
    #1;
    chk("fl_busy", dut.r_state, ST_BUSY);
    cyc();
    flush_i = 0;
    core_addr_i = 32'h40;
    inj_data = 32'hDEAD_BEEF;
    inj_req++;
    #1;
    chk("fl_drain", dut.r_state, ST_DRAIN);
    chk("fl_drain_req", bus_req_o, 1);
    chk("fl_drain_addr", bus_addr_o, 32'h10);
    cyc();
    #1;
    chk("fl_ack_data", core_data_o, NOP);
    resp_en = 1;
    cyc();
    #1;
    chk("fl_idle", dut.r_state, ST_IDLE);
    chk("fl_idle_data", core_data_o, NOP);
    chk("fl_idle_stall", stallreq_o, 1);
    fetch(32'h40, mem(32'h40), 2);
    chk("fl_nreq", req_log.size(), 2);
    chk("fl_fresh", req_log[1], 32'h40);

    // Timeout with no ack.
    resp_en = 0;
    fetch(32'h100, NOP, TO + 1);
    chk("to_err", err_o, 1);
    chk("to_req", bus_req_o, 0);
    cyc();
    #1;
    chk("to_err_pulse", err_o, 0);
    chk("to_req_len", last_len, TO);
    chk("to_stall", stallreq_o, 0);

    // Reset mid-fetch, late ack afterwards.
    core_addr_i = 32'h200;
    cyc();
    #1;
    chk("rs_busy_req", bus_req_o, 1);
    rst = 1;
    #1;
    chk("rs_in_data", core_data_o, NOP);
    chk("rs_in_stall", stallreq_o, 1);
    cyc();
    rst = 0;
    core_ce_i = 0;
    inj_data = 32'hCAFE_F00D;
    inj_req++;
    #1;
    chk("rs_req", bus_req_o, 0);
    chk("rs_addr", bus_addr_o, 0);
    chk("rs_err", err_o, 0);
    cyc();
    #1;
    chk("rs_ack_req", bus_req_o, 0);
    cyc();
    #1;
    chk("rs_valid", dut.r_valid, 0);
    chk("rs_state", dut.r_state, ST_IDLE);
    core_ce_i = 1;
    #1;
    chk("rs_miss", stallreq_o, 1);
    chk("rs_miss_data", core_data_o, NOP);
    resp_en = 1;
    fetch(32'h200, mem(32'h200), 2);

    chk("err_pulses", err_cnt, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
